// File: rtl/line_renderer_pkg.sv
// Shared types for the line renderer: FSM states, the line slot record and hit-test widths.
// Slot storage is sized by LS_COORD_W/LS_COLOR_W; the renderer's COORD_W/COLOR_W must match them.
package renderer_pkg;

    localparam int LS_COORD_W = 9;
    localparam int LS_COLOR_W = 16;
    localparam int DIFF_W     = LS_COORD_W + 1;
    localparam int F_W        = 2 * LS_COORD_W + 2;

    typedef enum logic [2:0] {
        S_DELAY,
        S_EVAL,
        S_WRITE,
        S_START,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    typedef struct packed {
        logic                  enable;
        logic [LS_COLOR_W-1:0] color;
        logic [LS_COORD_W-1:0] x0;
        logic [LS_COORD_W-1:0] y0;
        logic [LS_COORD_W-1:0] x1;
        logic [LS_COORD_W-1:0] y1;
    } line_slot_t;

endpackage

// File: rtl/line_renderer_hit.sv
// Combinational hit test of one slot at (x, y): enable, inclusive bounding box and |F| <= THRESH.
// Zero latency, no flow control.
module line_hit_eval
    import renderer_pkg::*;
#(
    parameter int THRESH = 8
) (
    input  line_slot_t            slot,
    input  logic [LS_COORD_W-1:0] x,
    input  logic [LS_COORD_W-1:0] y,
    output logic                  hit
);

    logic signed [DIFF_W-1:0] dx, dy, rx, ry;
    logic signed [F_W-1:0]    dx_w, dy_w, rx_w, ry_w;
    logic signed [F_W-1:0]    f, f_abs;
    logic                     in_x, in_y;

    always_comb begin
        dx = $signed({1'b0, slot.x1}) - $signed({1'b0, slot.x0});
        dy = $signed({1'b0, slot.y1}) - $signed({1'b0, slot.y0});
        rx = $signed({1'b0, x})       - $signed({1'b0, slot.x0});
        ry = $signed({1'b0, y})       - $signed({1'b0, slot.y0});
        // Full-width products: at the coordinate extremes F needs every bit of F_W.
        dx_w = {{(F_W-DIFF_W){dx[DIFF_W-1]}}, dx};
        dy_w = {{(F_W-DIFF_W){dy[DIFF_W-1]}}, dy};
        rx_w = {{(F_W-DIFF_W){rx[DIFF_W-1]}}, rx};
        ry_w = {{(F_W-DIFF_W){ry[DIFF_W-1]}}, ry};
        f     = dy_w * rx_w - dx_w * ry_w;
        f_abs = f[F_W-1] ? -f : f;
        in_x  = ((x >= slot.x0) && (x <= slot.x1)) || ((x >= slot.x1) && (x <= slot.x0));
        in_y  = ((y >= slot.y0) && (y <= slot.y1)) || ((y >= slot.y1) && (y <= slot.y0));
        hit   = slot.enable && in_x && in_y && (f_abs <= F_W'(THRESH));
    end

endmodule

// File: rtl/line_renderer.sv
// Rasterises one row (NUM_LINES+1 clocks per pixel) into the driver's row buffer, then pulses start.
// Stalls in WAIT_ACK/WAIT_DONE on the driver's busy; vertex writes go to a staging bank committed at frame wrap.
module line_renderer
    import renderer_pkg::*;
#(
    parameter int                 WIDTH          = 320,
    parameter int                 HEIGHT         = 480,
    parameter int                 COORD_W        = 9,
    parameter int                 COLOR_W        = 16,
    parameter int                 NUM_LINES      = 8,
    parameter int                 THRESH         = 8,
    parameter logic [COLOR_W-1:0] BG_COLOR       = 16'h0000,
    parameter int                 STARTUP_CYCLES = 27000000,
    localparam int                IDX_W          = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 vertexWrite,
    input  logic [IDX_W-1:0]     vertexIndex,
    input  logic [4*COORD_W-1:0] vertexData,
    input  logic [COLOR_W-1:0]   vertexColor,
    input  logic                 vertexEnable,
    output logic                 start,
    input  logic                 busy,
    output logic [COORD_W-1:0]   writeAddress,
    output logic [COLOR_W-1:0]   pixelData,
    output logic                 writeEnable,
    output logic [COORD_W-1:0]   rowY,
    output logic                 frameDone
);

    state_t               state_q, state_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [COORD_W-1:0]   x_q, x_d, row_q, row_d, addr_q, addr_d;
    logic [IDX_W-1:0]     k_q, k_d;
    logic [COLOR_W-1:0]   color_q, color_d, pix_q, pix_d;
    logic                 start_q, start_d, we_q, we_d, fd_q, fd_d;
    line_slot_t           stage_q  [NUM_LINES];
    line_slot_t           stage_d  [NUM_LINES];
    line_slot_t           active_q [NUM_LINES];
    line_slot_t           active_d [NUM_LINES];
    line_slot_t           cur_slot;
    logic                 hit;
    logic [COLOR_W-1:0]   resolved;

    assign cur_slot = active_q[k_q];

    line_hit_eval #(.THRESH(THRESH)) u_hit (
        .slot (cur_slot),
        .x    (x_q),
        .y    (row_q),
        .hit  (hit)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        k_d      = k_q;
        row_d    = row_q;
        color_d  = color_q;
        addr_d   = addr_q;
        pix_d    = pix_q;
        fd_d     = 1'b0;
        stage_d  = stage_q;
        active_d = active_q;
        // Ascending slot scan: a later hit overwrites, so the highest index wins.
        resolved = hit ? cur_slot.color : ((k_q == '0) ? BG_COLOR : color_q);

        case (state_q)
            S_DELAY: begin
                if ({1'b0, cnt_q} + 33'd1 >= 33'(STARTUP_CYCLES)) begin
                    state_d = S_EVAL;
                    x_d     = '0;
                    k_d     = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_EVAL: begin
                color_d = resolved;
                if (k_q == IDX_W'(NUM_LINES - 1)) begin
                    state_d = S_WRITE;
                    addr_d  = x_q;
                    pix_d   = resolved;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_WRITE: begin
                if (x_q < COORD_W'(WIDTH - 1)) begin
                    x_d     = x_q + 1'b1;
                    k_d     = '0;
                    state_d = S_EVAL;
                end else begin
                    state_d = S_START;
                end
            end
            S_START:    state_d = S_WAIT_ACK;
            S_WAIT_ACK: if (busy) state_d = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (!busy) begin
                    x_d     = '0;
                    k_d     = '0;
                    state_d = S_EVAL;
                    if (row_q == COORD_W'(HEIGHT - 1)) begin
                        row_d    = '0;
                        fd_d     = 1'b1;
                        active_d = stage_q;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: state_d = S_DELAY;
        endcase

        if (vertexWrite) begin
            stage_d[vertexIndex].enable = vertexEnable;
            stage_d[vertexIndex].color  = vertexColor;
            stage_d[vertexIndex].x0     = vertexData[COORD_W-1:0];
            stage_d[vertexIndex].y0     = vertexData[2*COORD_W-1:COORD_W];
            stage_d[vertexIndex].x1     = vertexData[3*COORD_W-1:2*COORD_W];
            stage_d[vertexIndex].y1     = vertexData[4*COORD_W-1:3*COORD_W];
        end

        we_d    = (state_d == S_WRITE);
        start_d = (state_d == S_START);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_DELAY;
            cnt_q   <= '0;
            x_q     <= '0;
            k_q     <= '0;
            row_q   <= '0;
            color_q <= '0;
            addr_q  <= '0;
            pix_q   <= '0;
            start_q <= 1'b0;
            we_q    <= 1'b0;
            fd_q    <= 1'b0;
            for (int i = 0; i < NUM_LINES; i++) begin
                stage_q[i]  <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            k_q      <= k_d;
            row_q    <= row_d;
            color_q  <= color_d;
            addr_q   <= addr_d;
            pix_q    <= pix_d;
            start_q  <= start_d;
            we_q     <= we_d;
            fd_q     <= fd_d;
            stage_q  <= stage_d;
            active_q <= active_d;
        end
    end

    assign start        = start_q;
    assign writeEnable  = we_q;
    assign writeAddress = addr_q;
    assign pixelData    = pix_q;
    assign rowY         = row_q;
    assign frameDone    = fd_q;

endmodule
